// File: rtl/lp_pkg.sv
// Shared types and width helpers for the 2-variable integer LP grid solver.
package lp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_e;

    // A coefficient times a box coordinate (B_W+1 bits) needs one bit more than this.
    function automatic int prod_w(input int coef_w, input int b_w);
        return coef_w + b_w;
    endfunction

    // Wide enough for a1*x1 + a2*x2 with no intermediate wrap.
    function automatic int acc_w(input int coef_w, input int b_w);
        return prod_w(coef_w, b_w) + 2;
    endfunction

    function automatic longint sat_hi(input int b_w);
        return (64'sd1 <<< (b_w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int b_w);
        return -(64'sd1 <<< (b_w - 1));
    endfunction

endpackage

// File: rtl/lp_point_eval.sv
// Combinational evaluation of one grid point: feasibility over all rows and objective value.
module lp_point_eval
    import lp_pkg::*;
#(
    parameter int COEF_W = 6,
    parameter int B_W    = 12,
    parameter int N_CON  = 6
) (
    input  logic [B_W:0]                    x1,
    input  logic [B_W:0]                    x2,
    input  logic [COEF_W-1:0]               c1,
    input  logic [COEF_W-1:0]               c2,
    input  logic [N_CON-1:0][COEF_W-1:0]    a1,
    input  logic [N_CON-1:0][COEF_W-1:0]    a2,
    input  logic [N_CON-1:0][B_W-1:0]       b,
    input  logic                            mask,
    output logic                            feasible,
    output logic [COEF_W+B_W+1:0]           obj
);

    localparam int AW = acc_w(COEF_W, B_W);

    function automatic logic signed [AW-1:0] lin(input logic [COEF_W-1:0] ka,
                                                 input logic [COEF_W-1:0] kb);
        logic signed [AW-1:0] ea;
        logic signed [AW-1:0] eb;
        logic signed [AW-1:0] ex1;
        logic signed [AW-1:0] ex2;
        ea  = AW'($signed(ka));
        eb  = AW'($signed(kb));
        ex1 = AW'($signed(x1));
        ex2 = AW'($signed(x2));
        return ea * ex1 + eb * ex2;
    endfunction

    always_comb begin
        obj      = lin(c1, c2);
        feasible = mask;
        for (int r = 0; r < N_CON; r++) begin
            if (lin(a1[r], a2[r]) > AW'($signed(b[r]))) begin
                feasible = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lp_grid_solver.sv
// Brute-force 2-variable integer LP over the box given by axis-aligned rows, LANES points per cycle.
// Optional macro LP_ARGMAX_EN builds the argmax coordinate outputs; otherwise out_x1/out_x2 are 0.
module lp_grid_solver
    import lp_pkg::*;
#(
    parameter int COEF_W = 6,
    parameter int B_W    = 12,
    parameter int N_CON  = 6,
    parameter int LANES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [COEF_W-1:0] in_a1,
    input  logic [COEF_W-1:0] in_a2,
    input  logic [B_W-1:0]    in_b,
    output logic              out_valid,
    output logic              out_feasible,
    output logic [B_W-1:0]    out_max_value,
    output logic [B_W-1:0]    out_x1,
    output logic [B_W-1:0]    out_x2
);

    localparam int AW = acc_w(COEF_W, B_W);
    localparam int XW = B_W + 1;
    localparam int RW = $clog2(N_CON);
    localparam logic signed [AW-1:0] SAT_HI  = AW'(sat_hi(B_W));
    localparam logic signed [AW-1:0] SAT_LO  = AW'(sat_lo(B_W));
    localparam logic [B_W-1:0]       VAL_MIN = {1'b1, {(B_W-1){1'b0}}};

    state_e                      state_q, state_d;
    logic [RW-1:0]               row_q, row_d;
    logic [COEF_W-1:0]           c1_q, c1_d, c2_q, c2_d;
    logic [N_CON-1:0][COEF_W-1:0] a1_q, a1_d, a2_q, a2_d;
    logic [N_CON-1:0][B_W-1:0]   b_q, b_d;
    logic [3:0]                  seen_q, seen_d;
    logic signed [XW-1:0]        x1max_q, x1max_d, x1min_q, x1min_d;
    logic signed [XW-1:0]        x2max_q, x2max_d, x2min_q, x2min_d;
    logic signed [XW-1:0]        x1_q, x1_d, x2_q, x2_d;
    logic signed [AW-1:0]        best_q, best_d;
    logic                        found_q, found_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_feasible_q, out_feasible_d;
    logic [B_W-1:0]              out_value_q, out_value_d;
`ifdef LP_ARGMAX_EN
    logic signed [XW-1:0]        best_x1_q, best_x1_d, best_x2_q, best_x2_d;
    logic [B_W-1:0]              out_x1_q, out_x1_d, out_x2_q, out_x2_d;
`endif

    logic signed [XW-1:0]        nb_pos, nb_neg;
    logic                        a1_zero, a1_one, a1_m1, a2_zero, a2_one, a2_m1;
    logic signed [XW:0]          x1_step;
    logic                        end_row, bad_box, finish;
    logic [LANES-1:0]            lane_feas;
    logic [LANES-1:0][AW-1:0]    lane_obj;
    logic [LANES-1:0][XW-1:0]    lane_x1;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic lane_mask;
            assign lane_x1[gi] = x1_q + XW'(gi);
            assign lane_mask   = (state_q == SCAN) && ($signed(lane_x1[gi]) <= x1max_q);

            lp_point_eval #(
                .COEF_W (COEF_W),
                .B_W    (B_W),
                .N_CON  (N_CON)
            ) u_eval (
                .x1       (lane_x1[gi]),
                .x2       (x2_q),
                .c1       (c1_q),
                .c2       (c2_q),
                .a1       (a1_q),
                .a2       (a2_q),
                .b        (b_q),
                .mask     (lane_mask),
                .feasible (lane_feas[gi]),
                .obj      (lane_obj[gi])
            );
        end
    endgenerate

    function automatic logic [B_W-1:0] saturate(input logic signed [AW-1:0] v);
        if (v > SAT_HI) return SAT_HI[B_W-1:0];
        if (v < SAT_LO) return SAT_LO[B_W-1:0];
        return v[B_W-1:0];
    endfunction

    assign nb_pos  = {in_b[B_W-1], in_b};
    assign nb_neg  = -nb_pos;
    assign a1_zero = (in_a1 == '0);
    assign a1_one  = (in_a1 == COEF_W'(1));
    assign a1_m1   = (in_a1 == '1);
    assign a2_zero = (in_a2 == '0);
    assign a2_one  = (in_a2 == COEF_W'(1));
    assign a2_m1   = (in_a2 == '1);
    assign x1_step = (XW+1)'(x1_q) + (XW+1)'(LANES);
    assign end_row = x1_step > (XW+1)'(x1max_q);

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        c1_d           = c1_q;
        c2_d           = c2_q;
        a1_d           = a1_q;
        a2_d           = a2_q;
        b_d            = b_q;
        seen_d         = seen_q;
        x1max_d        = x1max_q;
        x1min_d        = x1min_q;
        x2max_d        = x2max_q;
        x2min_d        = x2min_q;
        x1_d           = x1_q;
        x2_d           = x2_q;
        best_d         = best_q;
        found_d        = found_q;
        out_valid_d    = 1'b0;
        out_feasible_d = out_feasible_q;
        out_value_d    = out_value_q;
`ifdef LP_ARGMAX_EN
        best_x1_d      = best_x1_q;
        best_x2_d      = best_x2_q;
        out_x1_d       = out_x1_q;
        out_x2_d       = out_x2_q;
`endif
        bad_box        = 1'b0;
        finish         = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    c1_d    = in_a1;
                    c2_d    = in_a2;
                    row_d   = '0;
                    seen_d  = '0;
                    found_d = 1'b0;
                    best_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    a1_d[row_q] = in_a1;
                    a2_d[row_q] = in_a2;
                    b_d[row_q]  = in_b;
                    // Axis-aligned rows tighten the box; they still act as ordinary rows too.
                    if (a1_one && a2_zero) begin
                        if (!seen_q[0] || nb_pos < x1max_q) x1max_d = nb_pos;
                        seen_d[0] = 1'b1;
                    end
                    if (a1_m1 && a2_zero) begin
                        if (!seen_q[1] || nb_neg > x1min_q) x1min_d = nb_neg;
                        seen_d[1] = 1'b1;
                    end
                    if (a1_zero && a2_one) begin
                        if (!seen_q[2] || nb_pos < x2max_q) x2max_d = nb_pos;
                        seen_d[2] = 1'b1;
                    end
                    if (a1_zero && a2_m1) begin
                        if (!seen_q[3] || nb_neg > x2min_q) x2min_d = nb_neg;
                        seen_d[3] = 1'b1;
                    end
                    if (row_q == RW'(N_CON - 1)) begin
                        bad_box = !(&seen_d) || (x1min_d > x1max_d) || (x2min_d > x2max_d);
                        x1_d    = x1min_d;
                        x2_d    = x2min_d;
                        if (bad_box) begin
                            finish = 1'b1;
                        end else begin
                            state_d = SCAN;
                        end
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            SCAN: begin
                // Strict greater-than keeps the earliest point (lower lane, earlier cycle) on ties.
                for (int l = 0; l < LANES; l++) begin
                    if (lane_feas[l] && (!found_d || $signed(lane_obj[l]) > best_d)) begin
                        found_d = 1'b1;
                        best_d  = $signed(lane_obj[l]);
`ifdef LP_ARGMAX_EN
                        best_x1_d = $signed(lane_x1[l]);
                        best_x2_d = x2_q;
`endif
                    end
                end
                if (end_row) begin
                    x1_d = x1min_q;
                    if (x2_q == x2max_q) begin
                        finish = 1'b1;
                    end else begin
                        x2_d = x2_q + {{(XW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    x1_d = x1_step[XW-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d        = DONE;
            out_valid_d    = 1'b1;
            out_feasible_d = found_d;
            out_value_d    = found_d ? saturate(best_d) : VAL_MIN;
`ifdef LP_ARGMAX_EN
            out_x1_d       = found_d ? best_x1_d[B_W-1:0] : '0;
            out_x2_d       = found_d ? best_x2_d[B_W-1:0] : '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            row_q          <= '0;
            c1_q           <= '0;
            c2_q           <= '0;
            a1_q           <= '0;
            a2_q           <= '0;
            b_q            <= '0;
            seen_q         <= '0;
            x1max_q        <= '0;
            x1min_q        <= '0;
            x2max_q        <= '0;
            x2min_q        <= '0;
            x1_q           <= '0;
            x2_q           <= '0;
            best_q         <= '0;
            found_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_feasible_q <= 1'b0;
            out_value_q    <= '0;
`ifdef LP_ARGMAX_EN
            best_x1_q      <= '0;
            best_x2_q      <= '0;
            out_x1_q       <= '0;
            out_x2_q       <= '0;
`endif
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            c1_q           <= c1_d;
            c2_q           <= c2_d;
            a1_q           <= a1_d;
            a2_q           <= a2_d;
            b_q            <= b_d;
            seen_q         <= seen_d;
            x1max_q        <= x1max_d;
            x1min_q        <= x1min_d;
            x2max_q        <= x2max_d;
            x2min_q        <= x2min_d;
            x1_q           <= x1_d;
            x2_q           <= x2_d;
            best_q         <= best_d;
            found_q        <= found_d;
            out_valid_q    <= out_valid_d;
            out_feasible_q <= out_feasible_d;
            out_value_q    <= out_value_d;
`ifdef LP_ARGMAX_EN
            best_x1_q      <= best_x1_d;
            best_x2_q      <= best_x2_d;
            out_x1_q       <= out_x1_d;
            out_x2_q       <= out_x2_d;
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign out_feasible  = out_feasible_q;
    assign out_max_value = out_value_q;
`ifdef LP_ARGMAX_EN
    assign out_x1        = out_x1_q;
    assign out_x2        = out_x2_q;
`else
    assign out_x1        = '0;
    assign out_x2        = '0;
`endif

endmodule

// File: tb/tb_lp_grid_solver.sv
// Directed table-driven bench for lp_grid_solver, plus reset-abort and back-to-back sequences.
module tb_lp_grid_solver;

    localparam int COEF_W = 6;
    localparam int B_W    = 12;
    localparam int N_CON  = 6;
    localparam int LANES  = 2;
    localparam int NVEC   = 8;
    localparam int BUDGET = 20000;
`ifdef LP_ARGMAX_EN
    localparam bit ARG_EN = 1'b1;
`else
    localparam bit ARG_EN = 1'b0;
`endif

    typedef struct packed {
        logic signed [COEF_W-1:0] a1;
        logic signed [COEF_W-1:0] a2;
        logic signed [B_W-1:0]    b;
    } row_t;

    typedef struct packed {
        logic signed [COEF_W-1:0] c1;
        logic signed [COEF_W-1:0] c2;
        row_t [N_CON-1:0]         rows;
        logic [15:0]              lat;
        logic                     feas;
        logic signed [B_W-1:0]    val;
        logic signed [B_W-1:0]    x1;
        logic signed [B_W-1:0]    x2;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [COEF_W-1:0] in_a1;
    logic [COEF_W-1:0] in_a2;
    logic [B_W-1:0]    in_b;
    logic              out_valid;
    logic              out_feasible;
    logic [B_W-1:0]    out_max_value;
    logic [B_W-1:0]    out_x1;
    logic [B_W-1:0]    out_x2;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    lp_grid_solver #(
        .COEF_W (COEF_W),
        .B_W    (B_W),
        .N_CON  (N_CON),
        .LANES  (LANES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_a1         (in_a1),
        .in_a2         (in_a2),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_feasible  (out_feasible),
        .out_max_value (out_max_value),
        .out_x1        (out_x1),
        .out_x2        (out_x2)
    );

    function automatic row_t mk(input int a1, input int a2, input int b);
        row_t r;
        r.a1 = COEF_W'(a1);
        r.a2 = COEF_W'(a2);
        r.b  = B_W'(b);
        return r;
    endfunction

    function automatic vec_t mkv(input int c1, input int c2,
                                 input row_t r0, input row_t r1, input row_t r2,
                                 input row_t r3, input row_t r4, input row_t r5,
                                 input int lat, input int feas, input int val,
                                 input int x1, input int x2);
        vec_t v;
        v.c1 = COEF_W'(c1);
        v.c2 = COEF_W'(c2);
        v.rows[0] = r0;
        v.rows[1] = r1;
        v.rows[2] = r2;
        v.rows[3] = r3;
        v.rows[4] = r4;
        v.rows[5] = r5;
        v.lat  = 16'(lat);
        v.feas = feas[0];
        v.val  = B_W'(val);
        v.x1   = B_W'(x1);
        v.x2   = B_W'(x2);
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Beat 0 then N_CON rows on consecutive cycles; in_valid is left high on the last beat.
    task automatic drive(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        in_a1    = v.c1;
        in_a2    = v.c2;
        in_b     = 12'h5a5;
        for (int r = 0; r < N_CON; r++) begin
            @(negedge clk);
            in_a1 = v.rows[r].a1;
            in_a2 = v.rows[r].a2;
            in_b  = v.rows[r].b;
        end
    endtask

    // Counts cycles after the last beat until out_valid; junk beats are offered while waiting.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat      = k;
                in_valid = 1'b0;
                break;
            end
            in_valid = 1'b1;
            in_a1    = 6'h15;
            in_a2    = 6'h2a;
            in_b     = 12'h7ff;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        longint ex1;
        longint ex2;
        ex1 = ARG_EN ? longint'($signed(v.x1)) : 64'sd0;
        ex2 = ARG_EN ? longint'($signed(v.x2)) : 64'sd0;
        $display("%s: latency %0d feasible %0b value %0d x1 %0d x2 %0d", tag, lat,
                 out_feasible, $signed(out_max_value), $signed(out_x1), $signed(out_x2));
        chk({tag, ".latency"},  lat, longint'(v.lat));
        chk({tag, ".feasible"}, longint'(out_feasible), longint'(v.feas));
        chk({tag, ".value"},    longint'($signed(out_max_value)), longint'($signed(v.val)));
        chk({tag, ".x1"},       longint'($signed(out_x1)), ex1);
        chk({tag, ".x2"},       longint'($signed(out_x2)), ex2);
    endtask

    initial begin
        int lat;
        int seen;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a1    = '0;
        in_a2    = '0;
        in_b     = '0;

        // c, six rows (a1,a2,b), latency from last beat, feasible, value, x1, x2
        vecs[0] = mkv(1, 1, mk(1,0,3), mk(-1,0,0), mk(0,1,2), mk(0,-1,0), mk(1,1,4), mk(-1,1,1),
                      7, 1, 4, 3, 1);
        vecs[1] = mkv(1, 1, mk(1,0,2), mk(-1,0,-5), mk(0,1,2), mk(0,-1,0), mk(0,0,0), mk(0,0,0),
                      1, 0, -2048, 0, 0);
        vecs[2] = mkv(1, 1, mk(1,0,3), mk(-1,0,0), mk(0,1,2), mk(0,0,0), mk(0,0,0), mk(0,0,0),
                      1, 0, -2048, 0, 0);
        vecs[3] = mkv(-1, -2, mk(1,0,3), mk(-1,0,0), mk(0,1,2), mk(0,-1,0), mk(1,1,100), mk(0,0,0),
                      7, 1, 0, 0, 0);
        vecs[4] = mkv(1, 1, mk(1,0,3), mk(-1,0,0), mk(0,1,2), mk(0,-1,0), mk(1,1,-1), mk(0,0,0),
                      7, 0, -2048, 0, 0);
        vecs[5] = mkv(1, 1, mk(-1,0,3), mk(1,0,-1), mk(0,-1,2), mk(0,1,-1), mk(0,0,0), mk(0,0,0),
                      5, 1, -2, -1, -1);
        vecs[6] = mkv(31, 31, mk(1,0,100), mk(-1,0,0), mk(0,1,100), mk(0,-1,0), mk(0,0,0), mk(0,0,0),
                      5152, 1, 2047, 100, 100);
        vecs[7] = mkv(2, -1, mk(1,0,5), mk(1,0,3), mk(-1,0,1), mk(0,1,2), mk(0,-1,0), mk(-1,0,0),
                      7, 1, 6, 3, 0);

        repeat (3) @(negedge clk);
        chk("reset.out_valid",    longint'(out_valid), 0);
        chk("reset.out_feasible", longint'(out_feasible), 0);
        chk("reset.value",        longint'(out_max_value), 0);
        chk("reset.x1",           longint'(out_x1), 0);
        chk("reset.x2",           longint'(out_x2), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            wait_result(lat);
            check_result($sformatf("vec%0d", i), vecs[i], lat);
            @(negedge clk);
            chk($sformatf("vec%0d.valid_drops", i), longint'(out_valid), 0);
            chk($sformatf("vec%0d.value_holds", i), longint'($signed(out_max_value)),
                longint'($signed(vecs[i].val)));
        end

        // Abort a problem in SCAN with reset: no strobe may follow, outputs return to 0.
        drive(vecs[0]);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.out_feasible", longint'(out_feasible), 0);
        chk("abort.value",        longint'(out_max_value), 0);
        rst_n = 1'b1;
        seen  = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        $display("abort: out_valid strobes after reset %0d", seen);
        chk("abort.no_valid", seen, 0);

        // Rerun, then start the next problem in the cycle right after out_valid.
        drive(vecs[0]);
        wait_result(lat);
        check_result("b2b_first", vecs[0], lat);
        drive(vecs[5]);
        wait_result(lat);
        check_result("b2b_second", vecs[5], lat);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
